pipelined_adder: RTL and testbench

- Parametrised successor to the combinational half adder: a WIDTH-bit adder built from CHUNK-bit ripple slices.
- One pipeline register sits between slices, so carry propagates one chunk per cycle.
- Valid/ready handshake on both sides; bubbles collapse.
- Used as the arithmetic datapath block where full-width single-cycle carry chains miss timing.

---
 rtl/pipelined_adder.sv | 118 +++++++++++
 tb/tb_pipelined_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into CHUNK-bit ripple slices, one register per slice, valid/ready on both ends.
// Optional macro PIPELINED_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / CHUNK;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (NSTAGE < 1)) begin : g_param_chk
    $fatal(1, "pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             vld [NSTAGE];
  logic [NSTAGE:0]  rdy;
  logic [WIDTH-1:0] a_r [NSTAGE];
  logic [WIDTH-1:0] b_r [NSTAGE];
  logic [WIDTH-1:0] s_r [NSTAGE];
  logic             c_r [NSTAGE];
  logic             cmsb_r;

  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             c0;

  // Subtraction is folded in before stage 0 so both builds share the same pipe.
  always_comb begin
    a0 = a;
    b0 = b;
    c0 = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    if (sub) begin
      b0 = ~b;
      c0 = 1'b1;
    end
`endif
  end

  assign rdy[NSTAGE] = out_ready;
  assign in_ready    = rdy[0] && !rst;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] ps;
    logic             pc;
    logic             pv;
    logic [CHUNK:0]   add;

    if (k == 0) begin : g_first
      assign pa = a0;
      assign pb = b0;
      assign ps = '0;
      assign pc = c0;
      assign pv = in_valid;
    end else begin : g_mid
      assign pa = a_r[k-1];
      assign pb = b_r[k-1];
      assign ps = s_r[k-1];
      assign pc = c_r[k-1];
      assign pv = vld[k-1];
    end

    assign rdy[k] = !vld[k] || rdy[k+1];
    assign add    = {1'b0, pa[k*CHUNK +: CHUNK]} + {1'b0, pb[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, pc};

    always_ff @(posedge clk) begin
      if (rst) begin
        vld[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end else if (rdy[k]) begin
        vld[k] <= pv;
        a_r[k] <= pa;
        b_r[k] <= pb;
        s_r[k] <= ps;
        s_r[k][k*CHUNK +: CHUNK] <= add[CHUNK-1:0];
        c_r[k] <= add[CHUNK];
      end
    end

    if (k == NSTAGE - 1) begin : g_last
      // Carry into the MSB recovered from the MSB's own sum bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          cmsb_r <= 1'b0;
        end else if (rdy[k]) begin
          cmsb_r <= pa[WIDTH-1] ^ pb[WIDTH-1] ^ add[CHUNK-1];
        end
      end
    end
  end

  assign out_valid = vld[NSTAGE-1];
  assign sum       = s_r[NSTAGE-1];
  assign cout      = c_r[NSTAGE-1];
  assign ovf       = cmsb_r ^ c_r[NSTAGE-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at WIDTH=32, CHUNK=8.
// Exercises PIPELINED_ADDER_SUB_EN vectors when that macro is defined.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int ncmp  = 0;
  int nfail = 0;

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single transaction into an empty pipe, checking latency and result.
  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts,
                         input logic [31:0] es, input logic ec, input logic eo);
    int cyc;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd4);
    chk({tag, "_sum"},  64'(sum),  64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"},  64'(ovf),  64'(eo));
  endtask

  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
    logic [32:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    v    = (x[31] == y[31]) && (full[31] != x[31]);
    return {v, full};
  endfunction

  logic [33:0] expq [$];
  logic [33:0] e;
  logic [31:0] held;
  int          nout, first, last, naccept, nleak;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    rst = 1'b0;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed arithmetic
    run_one("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    run_one("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("neg",    32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_one("novf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Throughput: 16 back-to-back random operands
    nout = 0; first = -1; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        e = expq.pop_front();
        chk("tp_sum",  64'(sum),  64'(e[31:0]));
        chk("tp_cout", 64'(cout), 64'(e[32]));
        chk("tp_ovf",  64'(ovf),  64'(e[33]));
        if (first < 0) first = i;
        last = i;
        nout++;
      end
      if (i < 16) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
        expq.push_back(ref_add(a, b, cin));
        #1 chk("tp_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("tp_count",       64'(nout), 64'd16);
    chk("tp_consecutive", 64'(last - first + 1), 64'd16);

    // Backpressure: stream 10 cycles with out_ready low
    expq.delete();
    out_ready = 1'b0; naccept = 0; held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (held == 32'd0) held = sum;
        chk("bp_hold", 64'(sum), 64'(held));
      end
      a = 32'h0100_0000 * (i + 1) + 32'h00FF_FFFF; b = 32'h0000_0001; cin = 1'b0;
      in_valid = 1'b1;
      #1 chk("bp_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      if (in_ready) begin
        expq.push_back(ref_add(a, b, cin));
        naccept++;
      end
    end
    chk("bp_accepted", 64'(naccept), 64'd4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    nout = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("bp_extra", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("bp_sum",  64'(sum),  64'(e[31:0]));
          chk("bp_cout", 64'(cout), 64'(e[32]));
        end
        nout++;
      end
      @(negedge clk);
    end
    chk("bp_count", 64'(nout), 64'd4);

    // Reset with 3 in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'h1111_1111 * (i + 1); b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_sum",       64'(sum),       64'd0);
    chk("mr_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1 chk("mr_rel_in_ready", 64'(in_ready), 64'd1);
    nleak = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) nleak++;
    end
    chk("mr_no_emit", 64'(nleak), 64'd0);

`ifdef PIPELINED_ADDER_SUB_EN
    run_one("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("sub_cin_ig", 32'h0000_0009, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b0);
    run_one("sub0_add",   32'h0000_0009, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_000E, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
